// File: rtl/boot_sequencer_pkg.sv
// Shared definitions for the boot sequencer: FSM state encoding, error
// codes and default geometry of the program RAM it fills.
package boot_sequencer_pkg;

  localparam int DEF_DATA_W = 8;   // RAM word / stream byte width
  localparam int DEF_ADDR_W = 5;   // RAM address width
  localparam int DEF_DEPTH  = 32;  // RAM words, also the longest legal image

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    RD,
    CMP,
    DONE,
    ERROR
  } seqState_e;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_LEN   = 2'd1;
  localparam logic [1:0] ERR_SUM   = 2'd2;
  localparam logic [1:0] ERR_ABORT = 2'd3;

endpackage

// File: rtl/boot_checksum.sv
// Wrapping accumulator used for both the write-side and read-side checksums.
//   clk     : rising-edge clock
//   reset   : synchronous active-low reset, clears the sum
//   clear   : clears the sum (wins over addEn)
//   addEn   : adds addData into the sum this cycle
//   addData : value to accumulate
//   sum     : current sum modulo 2^DATA_W
module boot_checksum
  import boot_sequencer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              addEn,
  input  logic [DATA_W-1:0] addData,
  output logic [DATA_W-1:0] sum
);

  // NOTE: state registers are written with <= so every flop samples the
  // pre-edge values of its neighbours; a blocking = here would create
  // order-dependent simulation that no longer matches the netlist.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sum <= '0;
    end else if (clear) begin
      sum <= '0;
    end else if (addEn) begin
      sum <= sum + addData;  // wraps naturally at DATA_W bits
    end
  end

endmodule

// File: rtl/boot_sequencer.sv
// Boot sequencer: owns the external program RAM while the CPU is held,
// streams an image into it over valid/ready, reads it back to verify a
// running checksum, then releases the CPU with a one-cycle start pulse.
//   clk, reset            : rising-edge clock, synchronous active-low reset
//   start, abort          : begin a load / cancel an active operation
//   load_len              : image length in bytes, legal 1..DEPTH
//   in_data/valid/ready   : byte stream handshake
//   mem_addr/wdata/we/re  : RAM port driven by the sequencer
//   mem_rdata             : RAM read data, valid the cycle after mem_re
//   cpu_hold, cpu_start   : CPU hold level and release pulse
//   busy, done, error     : state flags
//   err_code              : ERR_NONE / ERR_LEN / ERR_SUM / ERR_ABORT
//   checksum              : sum of accepted bytes
module boot_sequencer
  import boot_sequencer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   load_len,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_hold,
  output logic              cpu_start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [DATA_W-1:0] checksum
);

  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W + 1)'(DEPTH);

  seqState_e         state, stateNext;
  logic [ADDR_W:0]   lenReg;
  logic [ADDR_W-1:0] wcnt, rcnt;
  logic [DATA_W-1:0] byteReg;
  logic [DATA_W-1:0] wsum, rsum, rsumFinal;
  logic [1:0]        errCode, errNext;
  logic              startPulse;

  logic clrAll, acceptByte, wcntInc, rcntClr, rcntInc, rsumAdd, errLoad;
  logic lenLegal, lastWrite, lastRead;

  // Counters are ADDR_W bits; comparing against len-1 one bit wider lets a
  // full DEPTH-byte image finish at address DEPTH-1 without wrapping.
  assign lenLegal  = (load_len != '0) && (load_len <= MAX_LEN);
  assign lastWrite = ({1'b0, wcnt} == lenReg - 1'b1);
  assign lastRead  = ({1'b0, rcnt} == lenReg - 1'b1);
  // The final compare uses the sum including the byte arriving this cycle.
  assign rsumFinal = rsum + mem_rdata;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  // NOTE: every signal driven here gets a default before the case so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    stateNext  = state;
    clrAll     = 1'b0;
    acceptByte = 1'b0;
    wcntInc    = 1'b0;
    rcntClr    = 1'b0;
    rcntInc    = 1'b0;
    rsumAdd    = 1'b0;
    errLoad    = 1'b0;
    errNext    = ERR_NONE;

    case (state)
      IDLE, DONE, ERROR: begin
        if (start) begin
          if (lenLegal) begin
            clrAll    = 1'b1;
            stateNext = LOAD;
          end else begin
            errLoad   = 1'b1;
            errNext   = ERR_LEN;
            stateNext = ERROR;
          end
        end
      end
      LOAD, WRITE, RD, CMP: begin
        if (abort) begin
          // Abort wins over the handshake and the write of this cycle.
          errLoad   = 1'b1;
          errNext   = ERR_ABORT;
          stateNext = ERROR;
        end else begin
          case (state)
            LOAD: begin
              if (in_valid) begin
                acceptByte = 1'b1;
                stateNext  = WRITE;
              end
            end
            WRITE: begin
              if (lastWrite) begin
                rcntClr   = 1'b1;
                stateNext = RD;
              end else begin
                wcntInc   = 1'b1;
                stateNext = LOAD;
              end
            end
            RD: stateNext = CMP;
            default: begin  // CMP
              rsumAdd = 1'b1;
              if (lastRead) begin
                if (rsumFinal == wsum) begin
                  stateNext = DONE;
                end else begin
                  errLoad   = 1'b1;
                  errNext   = ERR_SUM;
                  stateNext = ERROR;
                end
              end else begin
                rcntInc   = 1'b1;
                stateNext = RD;
              end
            end
          endcase
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // NOTE: the program RAM lives outside this block and is deliberately not
  // cleared on reset; only the sequencer's own control registers are.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lenReg     <= '0;
      wcnt       <= '0;
      rcnt       <= '0;
      byteReg    <= '0;
      errCode    <= ERR_NONE;
      startPulse <= 1'b0;
    end else begin
      if (clrAll) begin
        lenReg  <= load_len;
        wcnt    <= '0;
        rcnt    <= '0;
        errCode <= ERR_NONE;
      end
      if (acceptByte) byteReg <= in_data;
      if (wcntInc)    wcnt    <= wcnt + 1'b1;
      if (rcntClr)    rcnt    <= '0;
      if (rcntInc)    rcnt    <= rcnt + 1'b1;
      if (errLoad)    errCode <= errNext;
      // High only for the first cycle spent in DONE.
      startPulse <= (stateNext == DONE) && (state != DONE);
    end
  end

  boot_checksum #(.DATA_W(DATA_W)) u_wsum (
    .clk     (clk),
    .reset   (reset),
    .clear   (clrAll),
    .addEn   (acceptByte),
    .addData (in_data),
    .sum     (wsum)
  );

  boot_checksum #(.DATA_W(DATA_W)) u_rsum (
    .clk     (clk),
    .reset   (reset),
    .clear   (clrAll),
    .addEn   (rsumAdd),
    .addData (mem_rdata),
    .sum     (rsum)
  );

  // Outputs decode the state register; abort only masks the write strobe.
  assign in_ready  = (state == LOAD);
  assign mem_we    = (state == WRITE) && !abort;
  assign mem_re    = (state == RD);
  assign mem_addr  = (state == WRITE) ? wcnt :
                     (state == RD)    ? rcnt : '0;
  assign mem_wdata = (state == WRITE) ? byteReg : '0;
  assign cpu_hold  = (state != DONE);
  assign cpu_start = startPulse;
  assign busy      = (state == LOAD) || (state == WRITE) ||
                     (state == RD)   || (state == CMP);
  assign done      = (state == DONE);
  assign error     = (state == ERROR);
  assign err_code  = errCode;
  assign checksum  = wsum;

endmodule

// File: tb/tb_boot_sequencer.sv
// Self-checking bench for boot_sequencer: models the external RAM, drives
// directed and random loads, and compares against a sum-based reference.
module tb_boot_sequencer;

  localparam int DW = 8;
  localparam int AW = 5;
  localparam int DP = 32;

  logic          clk = 1'b0;
  logic          reset, start, abort, in_valid;
  logic [AW:0]   load_len;
  logic [DW-1:0] in_data;
  logic          in_ready, mem_we, mem_re, cpu_hold, cpu_start;
  logic          busy, done, error;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata, checksum;
  logic [1:0]    err_code;

  always #5 clk = ~clk;

  boot_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .load_len  (load_len),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .cpu_hold  (cpu_hold),
    .cpu_start (cpu_start),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .err_code  (err_code),
    .checksum  (checksum)
  );

  // ---------------- environment: RAM and event monitors ----------------
  logic [DW-1:0]   ram [DP];
  logic [DW-1:0]   rdataQ;
  bit              corruptAddr1 = 1'b0;
  logic [AW+DW-1:0] writeLog[$];
  int              startPulses = 0;
  int              readCount   = 0;

  assign mem_rdata = rdataQ;

  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
      writeLog.push_back({mem_addr, mem_wdata});
    end
    if (mem_re) begin
      rdataQ    <= (corruptAddr1 && mem_addr == 5'd1) ? 8'h03 : ram[mem_addr];
      readCount <= readCount + 1;
    end
    if (cpu_start) startPulses <= startPulses + 1;
  end

  // ---------------- scoring ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] stim[$];

  function automatic logic [DW-1:0] modelSum(input int len);
    int s = 0;
    for (int i = 0; i < len; i++) s += int'(stim[i]);
    return DW'(s % 256);
  endfunction

  // Image verifies when the bytes read back add up to the bytes written.
  function automatic bit modelOk(input int len);
    int s = 0;
    for (int i = 0; i < len; i++)
      s += (corruptAddr1 && i == 1) ? 3 : int'(stim[i]);
    return DW'(s % 256) == modelSum(len);
  endfunction

  // ---------------- driver ----------------
  int wbase, sbase, rbase;

  // mode 0: valid always high, 1: toggling, 2: random.
  task automatic runLoad(input string tag, input int len, input int mode, input int abortAt);
    int  idx = 0;
    bit  aborted = 1'b0;
    wbase = writeLog.size();
    sbase = startPulses;
    rbase = readCount;
    @(negedge clk);
    start    = 1'b1;
    load_len = (AW + 1)'(len);
    in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check({tag, " busy"}, busy, 1'b1);
    check({tag, " hold"}, cpu_hold, 1'b1);
    for (int cyc = 0; cyc < 600 && !(done || error); cyc++) begin
      in_valid = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
      in_data  = (idx < stim.size()) ? stim[idx] : 8'h00;
      if (abortAt >= 0 && in_valid && in_ready && idx == abortAt) begin
        abort   = 1'b1;
        aborted = 1'b1;
      end else if (in_valid && in_ready) begin
        idx++;
      end
      @(negedge clk);
      abort = 1'b0;
      if (aborted) break;
    end
    in_valid = 1'b0;
    check({tag, " finished"}, done | error, 1'b1);
  endtask

  task automatic checkWrites(input string tag, input int n);
    check({tag, " wcount"}, writeLog.size() - wbase, n);
    for (int i = 0; i < n && wbase + i < writeLog.size(); i++)
      check({tag, " write"}, writeLog[wbase + i], {AW'(i), stim[i]});
  endtask

  task automatic finishCheck(input string tag, input int len);
    bit ok = modelOk(len);
    check({tag, " done"}, done, ok);
    check({tag, " error"}, error, !ok);
    check({tag, " err_code"}, err_code, ok ? 2'd0 : 2'd2);
    check({tag, " checksum"}, checksum, modelSum(len));
    check({tag, " cpu_hold"}, cpu_hold, !ok);
    checkWrites(tag, len);
    check({tag, " reads"}, readCount - rbase, len);
    repeat (3) @(negedge clk);
    check({tag, " start pulses"}, startPulses - sbase, ok ? 1 : 0);
    check({tag, " cpu_start low"}, cpu_start, 1'b0);
  endtask

  task automatic badLen(input string tag, input int len);
    wbase = writeLog.size();
    @(negedge clk);
    start    = 1'b1;
    load_len = (AW + 1)'(len);
    @(negedge clk);
    start = 1'b0;
    check({tag, " error"}, error, 1'b1);
    check({tag, " err_code"}, err_code, 2'd1);
    check({tag, " cpu_hold"}, cpu_hold, 1'b1);
    repeat (2) @(negedge clk);
    check({tag, " no write"}, writeLog.size() - wbase, 0);
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, " in_ready"}, in_ready, 1'b0);
    check({tag, " mem_we"}, mem_we, 1'b0);
    check({tag, " mem_re"}, mem_re, 1'b0);
    check({tag, " mem_addr"}, mem_addr, 5'd0);
    check({tag, " mem_wdata"}, mem_wdata, 8'd0);
    check({tag, " cpu_hold"}, cpu_hold, 1'b1);
    check({tag, " cpu_start"}, cpu_start, 1'b0);
    check({tag, " busy"}, busy, 1'b0);
    check({tag, " done"}, done, 1'b0);
    check({tag, " error"}, error, 1'b0);
    check({tag, " err_code"}, err_code, 2'd0);
    check({tag, " checksum"}, checksum, 8'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int len;
    int seen;
    reset    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    load_len = '0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(negedge clk);
    checkResetOutputs("reset");
    reset = 1'b1;

    // Basic four-byte image.
    stim = '{8'h10, 8'h20, 8'h30, 8'h40};
    runLoad("len4", 4, 0, -1);
    finishCheck("len4", 4);

    // Illegal lengths.
    badLen("len0", 0);
    badLen("len33", 33);

    // Full-depth image with a stalling source.
    stim.delete();
    repeat (32) stim.push_back(8'hFF);
    runLoad("len32", 32, 1, -1);
    finishCheck("len32", 32);
    check("len32 last addr", writeLog[writeLog.size() - 1][AW+DW-1:DW], 5'd31);

    // Readback corruption at address 1.
    stim = '{8'h01, 8'h02};
    corruptAddr1 = 1'b1;
    runLoad("corrupt", 2, 0, -1);
    finishCheck("corrupt", 2);
    corruptAddr1 = 1'b0;

    // Abort on the cycle of the fourth handshake.
    stim = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    runLoad("abort", 8, 0, 3);
    check("abort error", error, 1'b1);
    check("abort err_code", err_code, 2'd3);
    check("abort hold", cpu_hold, 1'b1);
    repeat (5) @(negedge clk);
    checkWrites("abort", 3);

    stim = '{8'h55};
    runLoad("after abort", 1, 0, -1);
    finishCheck("after abort", 1);

    // Random images, random source stalls.
    for (int t = 0; t < 4; t++) begin
      len = int'($urandom_range(1, DP));
      stim.delete();
      for (int i = 0; i < len; i++) stim.push_back(8'($urandom));
      runLoad("random", len, 2, -1);
      finishCheck("random", len);
    end

    // Reset while verifying.
    stim = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
    @(negedge clk);
    start    = 1'b1;
    load_len = 6'd4;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    seen = 0;
    for (int cyc = 0; cyc < 100 && seen == 0; cyc++) begin
      in_data = stim[writeLog.size() % 4];
      if (mem_re) seen = 1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("mid-verify reached", seen, 1);
    check("mid-verify busy", busy, 1'b1);
    check("mid-verify no re", mem_re, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    checkResetOutputs("reset in cmp");
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle stays idle", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
